reorder_buffer: RTL and testbench

Circular reorder buffer that receives dispatched instructions from the decode/dispatch stage and retires them in program order. It accepts one entry per cycle on the dispatch write interface and exposes `rob_full` as that stage's back-pressure. It records out-of-order completions from execute. At retirement it returns the superseded physical register to the free list and publishes the committed rd→pd mapping to the architectural map.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/reorder_buffer_if.sv | 39 +++
 rtl/rob_ptr_ctrl.sv | 50 +++++
 rtl/reorder_buffer.sv | 80 ++++++++
 tb/tb_reorder_buffer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and widths, also used by the free list and map table.
package rob_pkg;

  localparam int PREG_WIDTH            = 7;
  localparam int AREG_WIDTH            = 5;
  localparam int ROB_DEPTH_DEFAULT     = 16;
  localparam int ROB_TAG_WIDTH_DEFAULT = 4;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [AREG_WIDTH-1:0] rd;
    logic [PREG_WIDTH-1:0] pd;
    logic [PREG_WIDTH-1:0] old_pd;
  } rob_entry_t;

  // An entry may leave the buffer only once it is both live and finished.
  function automatic logic entry_ready(input rob_entry_t e);
    return e.valid & e.done;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion and retirement signals between the ROB and its neighbours.
interface reorder_buffer_if
  import rob_pkg::*;
#(
  parameter int REG_FILE_ADDR_WIDTH = PREG_WIDTH,
  parameter int ROB_TAG_WIDTH       = ROB_TAG_WIDTH_DEFAULT
);

  logic                           write_rob;
  logic                           has_dest;
  logic [AREG_WIDTH-1:0]          rd;
  logic [REG_FILE_ADDR_WIDTH-1:0] pd;
  logic [REG_FILE_ADDR_WIDTH-1:0] old_pd;
  logic                           rob_full;
  logic                           rob_empty;
  logic [ROB_TAG_WIDTH-1:0]       alloc_tag;
  logic                           complete_valid;
  logic [ROB_TAG_WIDTH-1:0]       complete_tag;
  logic                           flush;
  logic                           retire_valid;
  logic                           free_reg_valid;
  logic [REG_FILE_ADDR_WIDTH-1:0] free_reg;
  logic                           commit_valid;
  logic [AREG_WIDTH-1:0]          commit_rd;
  logic [REG_FILE_ADDR_WIDTH-1:0] commit_pd;

  modport master (
    output write_rob, has_dest, rd, pd, old_pd, complete_valid, complete_tag, flush,
    input  rob_full, rob_empty, alloc_tag, retire_valid, free_reg_valid, free_reg,
           commit_valid, commit_rd, commit_pd
  );

  modport slave (
    input  write_rob, has_dest, rd, pd, old_pd, complete_valid, complete_tag, flush,
    output rob_full, rob_empty, alloc_tag, retire_valid, free_reg_valid, free_reg,
           commit_valid, commit_rd, commit_pd
  );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer and the alloc/retire enables.
module rob_ptr_ctrl #(
  parameter int ROB_DEPTH     = 16,
  parameter int ROB_TAG_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_rob,
  input  logic                     flush,
  input  logic                     head_ready,
  output logic [ROB_TAG_WIDTH-1:0] head,
  output logic [ROB_TAG_WIDTH-1:0] tail,
  output logic                     rob_full,
  output logic                     rob_empty,
  output logic                     alloc_en,
  output logic                     retire_en
);

  localparam logic [ROB_TAG_WIDTH:0] DEPTH_C = (ROB_TAG_WIDTH+1)'(ROB_DEPTH);

  logic [ROB_TAG_WIDTH-1:0] head_r;
  logic [ROB_TAG_WIDTH-1:0] tail_r;
  logic [ROB_TAG_WIDTH:0]   count_r;

  // Full blocks allocation even if the head retires this cycle: no same-cycle bypass.
  assign rob_full  = (count_r == DEPTH_C);
  assign rob_empty = (count_r == {(ROB_TAG_WIDTH+1){1'b0}});
  assign alloc_en  = write_rob & ~rob_full & ~flush;
  assign retire_en = head_ready & ~flush;
  assign head      = head_r;
  assign tail      = tail_r;

  // Pointer and occupancy registers; pointers wrap naturally at ROB_DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r  <= {ROB_TAG_WIDTH{1'b0}};
      tail_r  <= {ROB_TAG_WIDTH{1'b0}};
      count_r <= {(ROB_TAG_WIDTH+1){1'b0}};
    end else if (flush) begin
      head_r  <= {ROB_TAG_WIDTH{1'b0}};
      tail_r  <= {ROB_TAG_WIDTH{1'b0}};
      count_r <= {(ROB_TAG_WIDTH+1){1'b0}};
    end else begin
      head_r  <= head_r + ROB_TAG_WIDTH'(retire_en);
      tail_r  <= tail_r + ROB_TAG_WIDTH'(alloc_en);
      count_r <= count_r + (ROB_TAG_WIDTH+1)'(alloc_en) - (ROB_TAG_WIDTH+1)'(retire_en);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete, in-order retire.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int REG_FILE_ADDR_WIDTH = PREG_WIDTH,
  parameter int ROB_DEPTH           = ROB_DEPTH_DEFAULT,
  parameter int ROB_TAG_WIDTH       = ROB_TAG_WIDTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  reorder_buffer_if.slave   rob
);

  rob_entry_t               entries_r [ROB_DEPTH];
  rob_entry_t               head_entry_s;
  logic [ROB_TAG_WIDTH-1:0] head_s;
  logic [ROB_TAG_WIDTH-1:0] tail_s;
  logic                     alloc_en_s;
  logic                     retire_en_s;
  logic                     head_ready_s;

  assign head_entry_s = entries_r[head_s];
  assign head_ready_s = entry_ready(head_entry_s);

  rob_ptr_ctrl #(
    .ROB_DEPTH     (ROB_DEPTH),
    .ROB_TAG_WIDTH (ROB_TAG_WIDTH)
  ) u_ptr_ctrl (
    .clock      (clock),
    .reset      (reset),
    .write_rob  (rob.write_rob),
    .flush      (rob.flush),
    .head_ready (head_ready_s),
    .head       (head_s),
    .tail       (tail_s),
    .rob_full   (rob.rob_full),
    .rob_empty  (rob.rob_empty),
    .alloc_en   (alloc_en_s),
    .retire_en  (retire_en_s)
  );

  // Entry array: allocation at tail, completion by tag, valid cleared on retire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else if (rob.flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_r[i].valid <= 1'b0;
        entries_r[i].done  <= 1'b0;
      end
    end else begin
      // Tail is never live when alloc_en is set, so completion and allocation cannot collide.
      if (rob.complete_valid && entries_r[rob.complete_tag].valid) begin
        entries_r[rob.complete_tag].done <= 1'b1;
      end
      if (retire_en_s) begin
        entries_r[head_s].valid <= 1'b0;
      end
      if (alloc_en_s) begin
        entries_r[tail_s].valid    <= 1'b1;
        entries_r[tail_s].done     <= 1'b0;
        entries_r[tail_s].has_dest <= rob.has_dest;
        entries_r[tail_s].rd       <= rob.rd;
        entries_r[tail_s].pd       <= PREG_WIDTH'(rob.pd);
        entries_r[tail_s].old_pd   <= PREG_WIDTH'(rob.old_pd);
      end
    end
  end

  assign rob.alloc_tag      = tail_s;
  assign rob.retire_valid   = retire_en_s;
  assign rob.free_reg_valid = retire_en_s & head_entry_s.has_dest;
  assign rob.commit_valid   = retire_en_s & head_entry_s.has_dest;
  assign rob.free_reg       = REG_FILE_ADDR_WIDTH'(head_entry_s.old_pd);
  assign rob.commit_rd      = head_entry_s.rd;
  assign rob.commit_pd      = REG_FILE_ADDR_WIDTH'(head_entry_s.pd);

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  reorder_buffer_if #(.REG_FILE_ADDR_WIDTH(7), .ROB_TAG_WIDTH(4)) bus ();

  reorder_buffer #(
    .REG_FILE_ADDR_WIDTH (7),
    .ROB_DEPTH           (16),
    .ROB_TAG_WIDTH       (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rob   (bus)
  );

  typedef struct {
    int       tag;
    bit       has_dest;
    bit [4:0] rd;
    bit [6:0] pd;
    bit [6:0] old_pd;
    bit       done;
  } inst_t;

  inst_t prog[$];
  inst_t exp_q[$];
  int    m_tail;
  bit    chk_en;
  bit    exp_full, exp_empty;
  int    exp_tag;
  int    n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_tag();
    if (prog.size() > 0 && $urandom_range(0, 3) != 0)
      return prog[$urandom_range(0, prog.size() - 1)].tag;
    return int'($urandom_range(0, 15));
  endfunction

  // One cycle: drive inputs, record expectations, advance the program-order model.
  task automatic step(input bit w, input bit hd, input bit [4:0] r, input bit [6:0] p,
                      input bit [6:0] op, input bit cv, input int ct, input bit fl);
    bit do_ret;
    bit can_alloc;
    inst_t ni;
    @(posedge clock);
    #1;
    bus.write_rob      = w;
    bus.has_dest       = hd;
    bus.rd             = r;
    bus.pd             = p;
    bus.old_pd         = op;
    bus.complete_valid = cv;
    bus.complete_tag   = 4'(ct);
    bus.flush          = fl;
    exp_full  = (prog.size() == 16);
    exp_empty = (prog.size() == 0);
    exp_tag   = m_tail;
    do_ret    = !fl && prog.size() > 0 && prog[0].done;
    if (do_ret) exp_q.push_back(prog[0]);
    chk_en = 1'b1;
    if (fl) begin
      prog.delete();
      m_tail = 0;
    end else begin
      can_alloc = w && prog.size() < 16;
      if (cv) foreach (prog[i]) if (prog[i].tag == ct) prog[i].done = 1'b1;
      if (do_ret) void'(prog.pop_front());
      if (can_alloc) begin
        ni = '{tag: m_tail, has_dest: hd, rd: r, pd: p, old_pd: op, done: 1'b0};
        prog.push_back(ni);
        m_tail = (m_tail + 1) % 16;
      end
    end
  endtask

  task automatic rnd_step(input int wp, input int cp, input int fp);
    step($urandom_range(0, 99) < wp, $urandom_range(0, 3) != 0, 5'($urandom),
         7'($urandom), 7'($urandom), $urandom_range(0, 99) < cp, pick_tag(),
         $urandom_range(0, 99) < fp);
  endtask

  task automatic idle_inputs();
    bus.write_rob = 1'b0; bus.has_dest = 1'b0; bus.rd = 5'd0; bus.pd = 7'd0;
    bus.old_pd = 7'd0; bus.complete_valid = 1'b0; bus.complete_tag = 4'd0; bus.flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rob_empty"}, bus.rob_empty, 1'b1);
    chk({tag, "_rob_full"}, bus.rob_full, 1'b0);
    chk({tag, "_retire_valid"}, bus.retire_valid, 1'b0);
    chk({tag, "_alloc_tag"}, bus.alloc_tag, 4'd0);
    chk({tag, "_free_reg_valid"}, bus.free_reg_valid, 1'b0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each retirement.
  always @(negedge clock) begin
    inst_t e;
    if (chk_en && !reset) begin
      chk("rob_full", bus.rob_full, exp_full);
      chk("rob_empty", bus.rob_empty, exp_empty);
      chk("alloc_tag", bus.alloc_tag, exp_tag);
      chk("retire_valid", bus.retire_valid, exp_q.size() > 0);
      if (bus.retire_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("free_reg_valid", bus.free_reg_valid, e.has_dest);
        chk("commit_valid", bus.commit_valid, e.has_dest);
        if (e.has_dest) begin
          chk("free_reg", bus.free_reg, e.old_pd);
          chk("commit_rd", bus.commit_rd, e.rd);
          chk("commit_pd", bus.commit_pd, e.pd);
        end
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("free_reg_valid_idle", bus.free_reg_valid, 1'b0);
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; m_tail = 0; chk_en = 1'b0;
    idle_inputs();
    reset = 1'b1;
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_state("reset_hold");
    reset = 1'b0;

    repeat (400) rnd_step(75, 50, 2);
    repeat (40)  rnd_step(100, 0, 0);
    repeat (60)  rnd_step(50, 90, 0);
    repeat (200) rnd_step(70, 60, 12);

    step(1'b0, 1'b0, 5'd0, 7'd0, 7'd0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'(i + 1), 7'(10 + i), 7'(3 + i), 1'b0, 0, 1'b0);
    @(negedge clock);
    #2;
    chk_en = 1'b0;
    idle_inputs();
    reset = 1'b1;
    #1;
    check_reset_state("midrun_reset");
    prog.delete();
    exp_q.delete();
    m_tail = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    repeat (200) rnd_step(70, 60, 3);
    repeat (40)  rnd_step(0, 100, 0);
    step(1'b0, 1'b0, 5'd0, 7'd0, 7'd0, 1'b0, 0, 1'b0);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
